// File: rtl/ps2_key_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder_pkg
// Description : Scan-code constants, receiver FSM encoding and the key map
//               shared by the PS/2 receiver and the key-decode bank.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_key_decoder_pkg;

  // Scan-code set 2 bytes of interest
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_W   = 8'h1D;
  localparam logic [7:0] SC_S   = 8'h1B;
  localparam logic [7:0] SC_A   = 8'h1C;
  localparam logic [7:0] SC_D   = 8'h23;
  localparam logic [7:0] SC_UP  = 8'h75;
  localparam logic [7:0] SC_DN  = 8'h72;
  localparam logic [7:0] SC_LT  = 8'h6B;
  localparam logic [7:0] SC_RT  = 8'h74;

  // Bit positions of the held-key vector
  localparam logic [2:0] KEY_P1_UP    = 3'd0;
  localparam logic [2:0] KEY_P1_DOWN  = 3'd1;
  localparam logic [2:0] KEY_P1_LEFT  = 3'd2;
  localparam logic [2:0] KEY_P1_RIGHT = 3'd3;
  localparam logic [2:0] KEY_P2_UP    = 3'd4;
  localparam logic [2:0] KEY_P2_DOWN  = 3'd5;
  localparam logic [2:0] KEY_P2_LEFT  = 3'd6;
  localparam logic [2:0] KEY_P2_RIGHT = 3'd7;

  // Frame receiver states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } key_sel_t;

  // Map {extended, code} onto a key-vector position; keypad codes without
  // the E0 prefix (and E1/Pause) fall through as unmapped.
  function automatic key_sel_t keyLookup(input logic ext, input logic [7:0] code);
    key_sel_t sel;
    sel.hit = 1'b1;
    sel.idx = KEY_P1_UP;
    case ({ext, code})
      {1'b0, SC_W}:  sel.idx = KEY_P1_UP;
      {1'b0, SC_S}:  sel.idx = KEY_P1_DOWN;
      {1'b0, SC_A}:  sel.idx = KEY_P1_LEFT;
      {1'b0, SC_D}:  sel.idx = KEY_P1_RIGHT;
      {1'b1, SC_UP}: sel.idx = KEY_P2_UP;
      {1'b1, SC_DN}: sel.idx = KEY_P2_DOWN;
      {1'b1, SC_LT}: sel.idx = KEY_P2_LEFT;
      {1'b1, SC_RT}: sel.idx = KEY_P2_RIGHT;
      default:       sel.hit = 1'b0;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_key_decoder_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 device-to-host receiver. Synchronises and filters the
//               bus lines, detects falling clock edges and deserialises
//               11-bit frames into rx_data / rx_valid / rx_err.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_clkSync;
  logic [1:0]    r_datSync;
  logic [FW-1:0] r_filtCnt;
  logic          r_clkFilt;
  logic          r_fallStb;
  logic          w_fall;

  rx_state_t     r_state;
  rx_state_t     w_stateNext;
  logic [3:0]    r_bitCnt;
  logic [TW-1:0] r_toCnt;
  logic [7:0]    r_shift;
  logic          r_startBit;
  logic          r_parity;
  logic          w_timeout;
  logic          w_good;
  logic          w_dataBit;

  logic [7:0]    r_rxData;
  logic          r_rxValid;
  logic          r_rxErr;

  assign w_dataBit = r_datSync[1];

  // Two-flop synchronisers; reset to the idle (high) bus level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clkSync <= 2'b11;
      r_datSync <= 2'b11;
    end else begin
      r_clkSync <= {r_clkSync[0], ps2ClkIn};
      r_datSync <= {r_datSync[0], ps2DataIn};
    end
  end

  // The filtered level flips on the FILTER_LEN-th consecutive differing sample
  assign w_fall = r_clkFilt & ~r_clkSync[1] & (r_filtCnt == FILT_MAX);

  // Glitch filter on ps2_clk plus registered falling-edge strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_filtCnt <= '0;
      r_clkFilt <= 1'b1;
      r_fallStb <= 1'b0;
    end else begin
      r_fallStb <= w_fall;
      if (r_clkSync[1] == r_clkFilt) begin
        r_filtCnt <= '0;
      end else if (r_filtCnt == FILT_MAX) begin
        r_clkFilt <= r_clkSync[1];
        r_filtCnt <= '0;
      end else begin
        r_filtCnt <= r_filtCnt + 1'b1;
      end
    end
  end

  // Frame state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_stateNext;
  end

  // Next-state logic: edges drive the frame, only DATA can time out
  always_comb begin
    w_stateNext = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_fallStb) w_stateNext = ST_DATA;
      end
      ST_DATA: begin
        if (r_fallStb) begin
          if (r_bitCnt == 4'd9) w_stateNext = ST_CHECK;
        end else if (r_toCnt == TO_MAX) begin
          w_stateNext = ST_IDLE;
          w_timeout   = 1'b1;
        end
      end
      ST_CHECK: w_stateNext = ST_IDLE;
      default:  w_stateNext = ST_IDLE;
    endcase
  end

  // Frame is judged on the stop-bit strobe so the result lands in CHECK
  assign w_good = ~r_startBit & (^{r_shift, r_parity}) & w_dataBit;

  // Shift register, bit/timeout counters and the result pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitCnt   <= '0;
      r_toCnt    <= '0;
      r_shift    <= '0;
      r_startBit <= 1'b1;
      r_parity   <= 1'b0;
      r_rxData   <= '0;
      r_rxValid  <= 1'b0;
      r_rxErr    <= 1'b0;
    end else begin
      r_rxValid <= 1'b0;
      r_rxErr   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_bitCnt <= '0;
          r_toCnt  <= '0;
          if (r_fallStb) r_startBit <= w_dataBit;
        end
        ST_DATA: begin
          if (r_fallStb) begin
            r_toCnt  <= '0;
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt < 4'd8) begin
              r_shift <= {w_dataBit, r_shift[7:1]};
            end else if (r_bitCnt == 4'd8) begin
              r_parity <= w_dataBit;
            end else if (w_good) begin
              r_rxData  <= r_shift;
              r_rxValid <= 1'b1;
            end else begin
              r_rxErr <= 1'b1;
            end
          end else if (w_timeout) begin
            r_rxErr <= 1'b1;
          end else begin
            r_toCnt <= r_toCnt + 1'b1;
          end
        end
        default: begin
          r_bitCnt <= '0;
          r_toCnt  <= '0;
        end
      endcase
    end
  end

  assign rx_data  = r_rxData;
  assign rx_valid = r_rxValid;
  assign rx_err   = r_rxErr;

endmodule
`default_nettype wire

// File: rtl/ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_decoder
// Description : Receive-only PS/2 keyboard front end. Decodes make/break
//               scan codes into eight held-key levels for two players.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_decoder
  import ps2_key_decoder_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  // Both bus lines are only read; the host never pulls them low
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p1_left,
  output logic       p1_right,
  output logic       p2_up,
  output logic       p2_down,
  output logic       p2_left,
  output logic       p2_right
);

  logic       r_ext;
  logic       r_brk;
  logic [7:0] r_keys;
  key_sel_t   w_sel;

  ps2_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .ps2ClkIn  (ps2_clk),
    .ps2DataIn (ps2_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err)
  );

  assign w_sel = keyLookup(r_ext, rx_data);

  // Prefix flags and held-key bank, updated per received byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ext  <= 1'b0;
      r_brk  <= 1'b0;
      r_keys <= '0;
    end else if (rx_err) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (rx_valid) begin
      if (rx_data == SC_EXT) begin
        r_ext <= 1'b1;
      end else if (rx_data == SC_BRK) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        if (w_sel.hit) r_keys[w_sel.idx] <= ~r_brk;
      end
    end
  end

  assign p1_up    = r_keys[KEY_P1_UP];
  assign p1_down  = r_keys[KEY_P1_DOWN];
  assign p1_left  = r_keys[KEY_P1_LEFT];
  assign p1_right = r_keys[KEY_P1_RIGHT];
  assign p2_up    = r_keys[KEY_P2_UP];
  assign p2_down  = r_keys[KEY_P2_DOWN];
  assign p2_left  = r_keys[KEY_P2_LEFT];
  assign p2_right = r_keys[KEY_P2_RIGHT];

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_decoder
// Description : Self-checking bench; a modelled PS/2 keyboard sends frames
//               and a key-state reference model predicts the outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_decoder;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 400;
  localparam int HALF           = 25;   // device clock half period in clk cycles

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic devClk = 1'b1;
  logic devData = 1'b1;
  wire  ps2Clk;
  wire  ps2Data;
  assign ps2Clk  = devClk;
  assign ps2Data = devData;

  logic [7:0] rx_data;
  logic rx_valid, rx_err;
  logic p1_up, p1_down, p1_left, p1_right, p2_up, p2_down, p2_left, p2_right;
  wire [7:0] keys = {p2_right, p2_left, p2_down, p2_up, p1_right, p1_left, p1_down, p1_up};

  ps2_key_decoder #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2Clk), .ps2_data(ps2Data),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
    .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Observed pulse activity
  int validCnt = 0, errCnt = 0, latBad = 0, widthBad = 0;
  logic [7:0] lastData = 8'h00;
  logic prevValid = 1'b0, prevErr = 1'b0;
  logic [7:0] prevKeys = 8'h00;

  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid) begin
        validCnt = validCnt + 1;
        lastData = rx_data;
      end
      if (rx_err) errCnt = errCnt + 1;
      if ((rx_valid && prevValid) || (rx_err && prevErr)) widthBad = widthBad + 1;
      if (keys !== prevKeys && !prevValid) latBad = latBad + 1;
    end
    prevValid = rx_valid;
    prevErr   = rx_err;
    prevKeys  = keys;
  end

  // Reference model: held keys plus pending prefixes
  logic [7:0] mKeys = 8'h00;
  bit mExt = 0, mBrk = 0;

  function automatic int keyIdx(bit ext, logic [7:0] code);
    if (!ext) begin
      if (code == 8'h1D) return 0;
      if (code == 8'h1B) return 1;
      if (code == 8'h1C) return 2;
      if (code == 8'h23) return 3;
    end else begin
      if (code == 8'h75) return 4;
      if (code == 8'h72) return 5;
      if (code == 8'h6B) return 6;
      if (code == 8'h74) return 7;
    end
    return -1;
  endfunction

  task automatic modelByte(input logic [7:0] b);
    int k;
    if (b == 8'hE0) mExt = 1;
    else if (b == 8'hF0) mBrk = 1;
    else begin
      k = keyIdx(mExt, b);
      if (k >= 0) mKeys[k] = !mBrk;
      mExt = 0;
      mBrk = 0;
    end
  endtask

  task automatic waitCyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device sends the first nbits of a frame; data changes mid-high phase
  task automatic sendFrame(input logic [7:0] b, input bit flip, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      devData = bits[i];
      waitCyc(HALF / 2);
      devClk = 1'b0;
      waitCyc(HALF);
      devClk = 1'b1;
      waitCyc(HALF / 2);
    end
    devData = 1'b1;
    waitCyc(10);
  endtask

  task automatic sendByte(input logic [7:0] b);
    sendFrame(b, 0, 11);
    modelByte(b);
  endtask

  task automatic test_reset;
    waitCyc(3);
    total++; if (keys !== 8'h00) begin bad++; $display("FAIL reset_keys got=%h exp=00", keys); end
    total++; if (rx_valid !== 1'b0 || rx_err !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", rx_valid, rx_err); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    reset = 1'b1;
    waitCyc(20);
  endtask

  task automatic test_make_break;
    int v0;
    v0 = validCnt;
    sendByte(8'h1D);
    total++; if (validCnt !== v0 + 1) begin bad++; $display("FAIL w_make_valid got=%0d exp=%0d", validCnt, v0 + 1); end
    total++; if (lastData !== 8'h1D) begin bad++; $display("FAIL w_make_data got=%h exp=1d", lastData); end
    total++; if (keys !== 8'h01 || keys !== mKeys) begin bad++; $display("FAIL w_make_keys got=%h exp=01", keys); end
    sendByte(8'hF0);
    sendByte(8'h1D);
    total++; if (keys !== 8'h00) begin bad++; $display("FAIL w_break_keys got=%h exp=00", keys); end
  endtask

  task automatic test_extended;
    int v0;
    sendByte(8'hE0);
    sendByte(8'h75);
    total++; if (keys !== 8'h10) begin bad++; $display("FAIL ext_make_keys got=%h exp=10", keys); end
    sendByte(8'hE0);
    sendByte(8'hF0);
    sendByte(8'h75);
    total++; if (keys !== 8'h00) begin bad++; $display("FAIL ext_break_keys got=%h exp=00", keys); end
    v0 = validCnt;
    sendByte(8'h75);
    total++; if (keys !== 8'h00 || validCnt !== v0 + 1) begin bad++; $display("FAIL keypad_unmapped got=%h/%0d exp=00/%0d", keys, validCnt, v0 + 1); end
  endtask

  task automatic test_parity;
    int v0, e0;
    v0 = validCnt; e0 = errCnt;
    sendFrame(8'h1C, 1, 11);
    mExt = 0; mBrk = 0;
    total++; if (errCnt !== e0 + 1 || validCnt !== v0) begin bad++; $display("FAIL parity_err got=%0d/%0d exp=%0d/%0d", errCnt, validCnt, e0 + 1, v0); end
    total++; if (keys !== mKeys || p1_left !== 1'b0) begin bad++; $display("FAIL parity_keys got=%h exp=%h", keys, mKeys); end
    sendByte(8'h1C);
    total++; if (keys !== mKeys || p1_left !== 1'b1) begin bad++; $display("FAIL a_make_keys got=%h exp=%h", keys, mKeys); end
  endtask

  task automatic test_timeout;
    int e0, v0;
    e0 = errCnt; v0 = validCnt;
    sendFrame(8'h23, 0, 4);
    waitCyc(TIMEOUT_CYCLES + 50);
    mExt = 0; mBrk = 0;
    total++; if (errCnt !== e0 + 1 || validCnt !== v0) begin bad++; $display("FAIL timeout_err got=%0d/%0d exp=%0d/%0d", errCnt, validCnt, e0 + 1, v0); end
    sendByte(8'h23);
    total++; if (keys !== mKeys || p1_right !== 1'b1) begin bad++; $display("FAIL d_make_keys got=%h exp=%h", keys, mKeys); end
  endtask

  task automatic test_glitch;
    int v0, e0;
    logic [7:0] k0;
    v0 = validCnt; e0 = errCnt; k0 = keys;
    for (int i = 0; i < 5; i++) begin
      devClk = 1'b0;
      waitCyc(3);
      devClk = 1'b1;
      waitCyc(20);
    end
    total++; if (validCnt !== v0 || errCnt !== e0 || keys !== k0) begin bad++; $display("FAIL glitch_quiet got=%0d/%0d/%h exp=%0d/%0d/%h", validCnt, errCnt, keys, v0, e0, k0); end
    sendByte(8'h1B);
    total++; if (lastData !== 8'h1B || keys !== mKeys) begin bad++; $display("FAIL glitch_after got=%h/%h exp=1b/%h", lastData, keys, mKeys); end
  endtask

  task automatic test_random;
    logic [7:0] pool [12];
    logic [7:0] b;
    int v0, e0;
    bit flip;
    pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE1, 8'h11};
    for (int i = 0; i < 30; i++) begin
      b = ($urandom_range(0, 5) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
      flip = ($urandom_range(0, 7) == 0);
      v0 = validCnt; e0 = errCnt;
      if (flip) begin
        sendFrame(b, 1, 11);
        mExt = 0; mBrk = 0;
        total++; if (errCnt !== e0 + 1 || validCnt !== v0) begin bad++; $display("FAIL rand_err[%0d] got=%0d/%0d exp=%0d/%0d", i, errCnt, validCnt, e0 + 1, v0); end
      end else begin
        sendByte(b);
        total++; if (validCnt !== v0 + 1 || lastData !== b) begin bad++; $display("FAIL rand_data[%0d] got=%h exp=%h", i, lastData, b); end
      end
      total++; if (keys !== mKeys) begin bad++; $display("FAIL rand_keys[%0d] got=%h exp=%h", i, keys, mKeys); end
    end
  endtask

  task automatic test_reset_midframe;
    sendByte(8'h11);
    sendByte(8'h1D);
    sendByte(8'h1B);
    total++; if (keys !== mKeys || (keys & 8'h03) !== 8'h03) begin bad++; $display("FAIL held_pair got=%h exp=%h", keys, mKeys); end
    sendFrame(8'h23, 0, 5);
    reset = 1'b0;
    #1;
    total++; if (keys !== 8'h00 || rx_valid !== 1'b0 || rx_err !== 1'b0) begin bad++; $display("FAIL async_reset got=%h/%b%b exp=00/00", keys, rx_valid, rx_err); end
    mKeys = 8'h00; mExt = 0; mBrk = 0;
    waitCyc(5);
    reset = 1'b1;
    waitCyc(20);
    sendByte(8'h1B);
    total++; if (keys !== 8'h02 || keys !== mKeys) begin bad++; $display("FAIL post_reset got=%h exp=02", keys); end
  endtask

  task automatic test_timing;
    total++; if (latBad !== 0) begin bad++; $display("FAIL key_latency got=%0d exp=0", latBad); end
    total++; if (widthBad !== 0) begin bad++; $display("FAIL pulse_width got=%0d exp=0", widthBad); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_parity();
    test_timeout();
    test_glitch();
    test_random();
    test_reset_midframe();
    test_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
